// File: rtl/button_code_gen_if.sv
// Raw pushbutton inputs and the held selection code shared by the button front end and its environment.
interface button_code_gen_if;
    logic       btn_freq;
    logic       btn_lp;
    logic       btn_hp;
    logic [3:0] buttons;
    logic       code_update;

    modport master (output btn_freq, btn_lp, btn_hp, input buttons, code_update);
    modport slave  (input btn_freq, btn_lp, btn_hp, output buttons, code_update);
endinterface

// File: rtl/button_code_gen.sv
// Conditions three raw pushbuttons and turns each debounced press into a stepped 4-bit selection code.
module button_code_gen_deb #(
    parameter int DEBOUNCE_CYCLES = 480,
    parameter int CNT_W           = 20
) (
    input  logic clk_48,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);
    logic             sync1_q, sync2_q, deb_q, press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_48) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q   <= sync2_q;
                cnt_q   <= '0;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;
endmodule

module button_code_gen #(
    parameter int DEBOUNCE_CYCLES = 480,
    parameter int CNT_W           = 20
) (
    input  logic             clk_48,
    input  logic             reset,
    button_code_gen_if.slave bus
);
    localparam int NUM_BTN = 3;

    // Lane order: 0 = freq, 1 = low-pass, 2 = high-pass; also the service priority.
    logic [NUM_BTN-1:0] raw, press;
    assign raw = {bus.btn_hp, bus.btn_lp, bus.btn_freq};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        button_code_gen_deb #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk_48 (clk_48),
            .reset  (reset),
            .raw_i  (raw[g]),
            .press_o(press[g])
        );
    end

    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [2:0]         freq_idx_q, freq_idx_d;
    logic [1:0]         lp_idx_q, lp_idx_d;
    logic [1:0]         hp_idx_q, hp_idx_d;
    logic [3:0]         buttons_q, buttons_d;
    logic               code_update_q, code_update_d;

    always_comb begin
        pend_d        = pend_q;
        freq_idx_d    = freq_idx_q;
        lp_idx_d      = lp_idx_q;
        hp_idx_d      = hp_idx_q;
        buttons_d     = buttons_q;
        code_update_d = 1'b0;
        if (pend_q[0]) begin
            freq_idx_d    = freq_idx_q + 3'd1;
            buttons_d     = {1'b0, freq_idx_q + 3'd1};
            pend_d[0]     = 1'b0;
            code_update_d = 1'b1;
        end else if (pend_q[1]) begin
            lp_idx_d      = lp_idx_q + 2'd1;
            buttons_d     = {2'b10, lp_idx_q + 2'd1};
            pend_d[1]     = 1'b0;
            code_update_d = 1'b1;
        end else if (pend_q[2]) begin
            hp_idx_d      = hp_idx_q + 2'd1;
            buttons_d     = {2'b11, hp_idx_q + 2'd1};
            pend_d[2]     = 1'b0;
            code_update_d = 1'b1;
        end
        // A press landing in its own service cycle must survive the clear.
        pend_d = pend_d | press;
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            pend_q        <= '0;
            freq_idx_q    <= 3'd4;
            lp_idx_q      <= 2'd1;
            hp_idx_q      <= 2'd2;
            buttons_q     <= 4'd4;
            code_update_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            freq_idx_q    <= freq_idx_d;
            lp_idx_q      <= lp_idx_d;
            hp_idx_q      <= hp_idx_d;
            buttons_q     <= buttons_d;
            code_update_q <= code_update_d;
        end
    end

    assign bus.buttons     = buttons_q;
    assign bus.code_update = code_update_q;
endmodule

// File: tb/tb_button_code_gen.sv
// Directed checks of press timing, wrap-around, glitch rejection, priority and reset behaviour.
module tb_button_code_gen;
    localparam int D = 4;

    logic clk_48 = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cu_cnt = 0;

    button_code_gen_if bif();

    button_code_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk_48(clk_48),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk_48 = ~clk_48;

    always @(negedge clk_48) if (!reset && bif.code_update === 1'b1) cu_cnt++;

    // After ticks(n) we sit 1ns past the n-th rising edge since the call.
    task automatic ticks(input int n);
        repeat (n) @(posedge clk_48);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bif.btn_freq = v;
            1: bif.btn_lp   = v;
            default: bif.btn_hp = v;
        endcase
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        apply_reset();
        checks++; if (bif.buttons !== 4'd4 || bif.code_update !== 1'b0) begin errors++;
            $display("FAIL reset_state: got %0d/%b want 4/0", bif.buttons, bif.code_update); end
        ticks(30);
        checks++; if (bif.buttons !== 4'd4 || cu_cnt !== 0) begin errors++;
            $display("FAIL reset_idle: got %0d cu_cnt %0d want 4 0", bif.buttons, cu_cnt); end
        // Reset while the debounce counter is running.
        set_btn(0, 1'b1);
        ticks(5);
        reset = 1'b1; set_btn(0, 1'b0);
        ticks(1);
        reset = 1'b0;
        ticks(20);
        checks++; if (bif.buttons !== 4'd4 || cu_cnt !== 0) begin errors++;
            $display("FAIL reset_midcount: got %0d cu_cnt %0d want 4 0", bif.buttons, cu_cnt); end
        // Reset while a press is pending service.
        set_btn(0, 1'b1);
        ticks(D + 3);
        reset = 1'b1; set_btn(0, 1'b0);
        ticks(1);
        reset = 1'b0;
        ticks(20);
        checks++; if (bif.buttons !== 4'd4 || cu_cnt !== 0) begin errors++;
            $display("FAIL reset_midpend: got %0d cu_cnt %0d want 4 0", bif.buttons, cu_cnt); end
    endtask

    task automatic test_freq_wrap();
        logic [3:0] exp [4];
        int c0;
        exp[0] = 4'd5; exp[1] = 4'd6; exp[2] = 4'd7; exp[3] = 4'd0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            c0 = cu_cnt;
            set_btn(0, 1'b1);
            ticks(D + 3);
            checks++; if (bif.buttons !== ((i == 0) ? 4'd4 : exp[i-1]) || bif.code_update !== 1'b0) begin errors++;
                $display("FAIL freq_early[%0d]: got %0d/%b", i, bif.buttons, bif.code_update); end
            ticks(1);
            checks++; if (bif.buttons !== exp[i] || bif.code_update !== 1'b1) begin errors++;
                $display("FAIL freq_step[%0d]: got %0d/%b want %0d/1", i, bif.buttons, bif.code_update, exp[i]); end
            ticks(1);
            set_btn(0, 1'b0);
            ticks(D + 6);
            checks++; if (bif.buttons !== exp[i] || cu_cnt !== c0 + 1) begin errors++;
                $display("FAIL freq_hold[%0d]: got %0d pulses %0d want %0d 1", i, bif.buttons, cu_cnt - c0, exp[i]); end
        end
    endtask

    task automatic test_lp_glitch_wrap();
        logic [3:0] exp [3];
        int c0;
        exp[0] = 4'd10; exp[1] = 4'd11; exp[2] = 4'd8;
        apply_reset();
        c0 = cu_cnt;
        set_btn(1, 1'b1);
        ticks(D - 1);
        set_btn(1, 1'b0);
        ticks(D + 8);
        checks++; if (bif.buttons !== 4'd4 || cu_cnt !== c0) begin errors++;
            $display("FAIL lp_glitch: got %0d pulses %0d want 4 0", bif.buttons, cu_cnt - c0); end
        for (int i = 0; i < 3; i++) begin
            set_btn(1, 1'b1);
            ticks(D + 4);
            checks++; if (bif.buttons !== exp[i] || bif.code_update !== 1'b1) begin errors++;
                $display("FAIL lp_step[%0d]: got %0d/%b want %0d/1", i, bif.buttons, bif.code_update, exp[i]); end
            set_btn(1, 1'b0);
            ticks(D + 6);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        set_btn(0, 1'b1); set_btn(1, 1'b1); set_btn(2, 1'b1);
        ticks(D + 4);
        checks++; if (bif.buttons !== 4'd5 || bif.code_update !== 1'b1) begin errors++;
            $display("FAIL simul_freq: got %0d/%b want 5/1", bif.buttons, bif.code_update); end
        ticks(1);
        checks++; if (bif.buttons !== 4'd10 || bif.code_update !== 1'b1) begin errors++;
            $display("FAIL simul_lp: got %0d/%b want 10/1", bif.buttons, bif.code_update); end
        ticks(1);
        checks++; if (bif.buttons !== 4'd15 || bif.code_update !== 1'b1) begin errors++;
            $display("FAIL simul_hp: got %0d/%b want 15/1", bif.buttons, bif.code_update); end
        ticks(1);
        checks++; if (bif.buttons !== 4'd15 || bif.code_update !== 1'b0) begin errors++;
            $display("FAIL simul_done: got %0d/%b want 15/0", bif.buttons, bif.code_update); end
        set_btn(0, 1'b0); set_btn(1, 1'b0); set_btn(2, 1'b0);
        ticks(D + 6);
    endtask

    task automatic test_interleave();
        logic [3:0] exp [3];
        int         btn [3];
        exp[0] = 4'd10; exp[1] = 4'd5; exp[2] = 4'd11;
        btn[0] = 1;     btn[1] = 0;    btn[2] = 1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_btn(btn[i], 1'b1);
            ticks(D + 4);
            checks++; if (bif.buttons !== exp[i] || bif.code_update !== 1'b1) begin errors++;
                $display("FAIL interleave[%0d]: got %0d/%b want %0d/1", i, bif.buttons, bif.code_update, exp[i]); end
            set_btn(btn[i], 1'b0);
            ticks(D + 6);
        end
    endtask

    task automatic test_held_through_reset();
        int c0;
        reset = 1'b1;
        set_btn(0, 1'b1);
        ticks(3);
        reset = 1'b0;
        c0 = cu_cnt;
        ticks(D + 3);
        checks++; if (bif.buttons !== 4'd4) begin errors++;
            $display("FAIL held_early: got %0d want 4", bif.buttons); end
        ticks(1);
        checks++; if (bif.buttons !== 4'd5 || bif.code_update !== 1'b1) begin errors++;
            $display("FAIL held_press: got %0d/%b want 5/1", bif.buttons, bif.code_update); end
        ticks(20);
        set_btn(0, 1'b0);
        ticks(20);
        checks++; if (bif.buttons !== 4'd5 || cu_cnt !== c0 + 1) begin errors++;
            $display("FAIL held_once: got %0d pulses %0d want 5 1", bif.buttons, cu_cnt - c0); end
    endtask

    initial begin
        bif.btn_freq = 1'b0; bif.btn_lp = 1'b0; bif.btn_hp = 1'b0;
        test_reset();
        test_freq_wrap();
        test_lp_glitch_wrap();
        test_simultaneous();
        test_interleave();
        test_held_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
